// File: rtl/sd_image_server_if.sv
// Drive-request and image-memory signal bundle for sd_image_server.
// slave is the server's view; master is the drives/memory side.
interface sd_image_server_if #(
  parameter int unsigned NDR = 2
);
  logic [NDR-1:0][31:0] sd_lba;
  logic [NDR-1:0][5:0]  sd_blk_cnt;
  logic [NDR-1:0]       sd_rd;
  logic [NDR-1:0]       sd_wr;
  logic [NDR-1:0]       sd_ack;
  logic [13:0]          sd_buff_addr;
  logic [7:0]           sd_buff_dout;
  logic                 sd_buff_wr;
  logic [NDR-1:0][7:0]  sd_buff_din;

  logic [40:0]          mem_addr;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [7:0]           mem_wdata;
  logic                 mem_busy;
  logic [7:0]           mem_rdata;
  logic                 mem_rvalid;

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, mem_busy, mem_rdata, mem_rvalid,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, mem_busy, mem_rdata, mem_rvalid,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/sd_image_server.sv
// Round-robin server for drive block requests: streams 512-byte blocks between the
// image memory byte port and the granted drive's buffer. Bus NDR must equal clamp(DRIVES,1,4).
module sd_image_server #(
  parameter int unsigned DRIVES = 2
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               img_readonly,
  output logic               wr_err,
  sd_image_server_if.slave   bus
);
  localparam int unsigned NDR = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES);
  localparam int unsigned DW  = (NDR > 1) ? $clog2(NDR) : 1;
  localparam int unsigned IW  = 15;

  typedef enum logic [2:0] {IDLE, GRANT, RD_REQ, RD_WAIT, WR_ADDR, WR_DATA, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   drv_q, drv_d;
  logic            is_rd_q, is_rd_d;
  logic [31:0]     lba_q, lba_d;
  logic [IW-1:0]   total_q, total_d;
  logic [IW-1:0]   index_q, index_d;
  logic            pend_q, pend_d;
  logic            cap_q, cap_d;
  logic [7:0]      wbyte_q, wbyte_d;
  logic            disc_q, disc_d;
  logic [NDR-1:0]  ack_q, ack_d;
  logic [13:0]     baddr_q, baddr_d;
  logic [7:0]      bdout_q, bdout_d;
  logic            bwr_q, bwr_d;
  logic [40:0]     maddr_q, maddr_d;
  logic            mrd_q, mrd_d;
  logic            mwr_q, mwr_d;
  logic [7:0]      mwdata_q, mwdata_d;
  logic            wr_err_q, wr_err_d;

  logic            req_found;
  logic [DW-1:0]   req_win;
  logic [DW-1:0]   scan_idx;
  logic [5:0]      blk_lo;
  logic [IW-1:0]   index_inc;
  logic            last_byte;
  logic [40:0]     cur_addr;
  logic [7:0]      wr_byte;

  // Round-robin scan starting one past the last winner
  always_comb begin
    req_found = 1'b0;
    req_win   = ptr_q;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NDR; k++) begin
      scan_idx = DW'((32'(ptr_q) + k) % NDR);
      if (!req_found && (bus.sd_rd[scan_idx] || bus.sd_wr[scan_idx])) begin
        req_found = 1'b1;
        req_win   = scan_idx;
      end
    end
  end

  assign blk_lo    = bus.sd_blk_cnt[req_win] & 6'h1f;
  assign index_inc = index_q + IW'(1);
  assign last_byte = (index_inc == total_q);
  assign cur_addr  = {lba_q, 9'd0} + 41'(index_q);
  assign wr_byte   = cap_q ? wbyte_q : bus.sd_buff_din[drv_q];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    drv_d    = drv_q;
    is_rd_d  = is_rd_q;
    lba_d    = lba_q;
    total_d  = total_q;
    index_d  = index_q;
    pend_d   = pend_q;
    cap_d    = cap_q;
    wbyte_d  = wbyte_q;
    disc_d   = disc_q;
    ack_d    = ack_q;
    baddr_d  = baddr_q;
    bdout_d  = bdout_q;
    bwr_d    = 1'b0;
    maddr_d  = maddr_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    mwdata_d = mwdata_q;
    wr_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_found) begin
          drv_d          = req_win;
          ptr_d          = req_win;
          is_rd_d        = bus.sd_rd[req_win];
          lba_d          = bus.sd_lba[req_win];
          total_d        = {blk_lo + 6'd1, 9'd0};
          ack_d          = '0;
          ack_d[req_win] = 1'b1;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        index_d = '0;
        disc_d  = 1'b0;
        state_d = is_rd_q ? RD_REQ : WR_ADDR;
      end
      RD_REQ: begin
        if (!bus.mem_busy) begin
          mrd_d   = 1'b1;
          maddr_d = cur_addr;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          bdout_d = bus.mem_rdata;
          baddr_d = index_q[13:0];
          bwr_d   = 1'b1;
          index_d = index_inc;
          state_d = last_byte ? DONE : RD_REQ;
        end
      end
      WR_ADDR: begin
        baddr_d = index_q[13:0];
        pend_d  = 1'b1;
        cap_d   = 1'b0;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        // First cycle lets the drive buffer return data for the new address
        if (pend_q) begin
          pend_d = 1'b0;
        end else begin
          if (!cap_q) begin
            wbyte_d = bus.sd_buff_din[drv_q];
            cap_d   = 1'b1;
          end
          if (!bus.mem_busy) begin
            mwr_d    = !img_readonly;
            maddr_d  = cur_addr;
            mwdata_d = wr_byte;
            disc_d   = disc_q | img_readonly;
            index_d  = index_inc;
            if (last_byte) begin
              wr_err_d = disc_q | img_readonly;
              state_d  = DONE;
            end else begin
              state_d  = WR_ADDR;
            end
          end
        end
      end
      DONE: begin
        ack_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      drv_q    <= '0;
      is_rd_q  <= 1'b0;
      lba_q    <= '0;
      total_q  <= '0;
      index_q  <= '0;
      pend_q   <= 1'b0;
      cap_q    <= 1'b0;
      wbyte_q  <= '0;
      disc_q   <= 1'b0;
      ack_q    <= '0;
      baddr_q  <= '0;
      bdout_q  <= '0;
      bwr_q    <= 1'b0;
      maddr_q  <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      mwdata_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      drv_q    <= drv_d;
      is_rd_q  <= is_rd_d;
      lba_q    <= lba_d;
      total_q  <= total_d;
      index_q  <= index_d;
      pend_q   <= pend_d;
      cap_q    <= cap_d;
      wbyte_q  <= wbyte_d;
      disc_q   <= disc_d;
      ack_q    <= ack_d;
      baddr_q  <= baddr_d;
      bdout_q  <= bdout_d;
      bwr_q    <= bwr_d;
      maddr_q  <= maddr_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      mwdata_q <= mwdata_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.sd_ack       = ack_q;
  assign bus.sd_buff_addr = baddr_q;
  assign bus.sd_buff_dout = bdout_q;
  assign bus.sd_buff_wr   = bwr_q;
  assign bus.mem_addr     = maddr_q;
  assign bus.mem_rd       = mrd_q;
  assign bus.mem_wr       = mwr_q;
  assign bus.mem_wdata    = mwdata_q;
  assign wr_err           = wr_err_q;
endmodule

// File: tb/tb_sd_image_server.sv
// Scoreboard bench for sd_image_server: drivers push expected beats, monitors pop and compare.
module tb_sd_image_server;
  localparam int unsigned NDR = 2;

  typedef struct packed {
    logic [40:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic clk_sys = 1'b0;
  logic reset;
  logic img_readonly;
  logic wr_err;

  sd_image_server_if #(.NDR(NDR)) bus ();

  sd_image_server #(.DRIVES(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .img_readonly (img_readonly),
    .wr_err       (wr_err),
    .bus          (bus)
  );

  always #5 clk_sys = ~clk_sys;

  beat_t       exp_bwr[$];
  beat_t       exp_mwr[$];
  logic [40:0] exp_mrd[$];
  int          exp_ack[$];
  int checks = 0;
  int errors = 0;
  int bwr_seen = 0;
  int werr_seen = 0;
  int werr_exp = 0;
  bit rand_mode = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [40:0] a);
    return a[7:0];
  endfunction

  function automatic logic [7:0] buf_byte(input int d, input logic [13:0] a);
    logic [7:0] r;
    r = (a[7:0] * 8'd7) ^ {2'b00, a[13:8]} ^ 8'(d * 29 + 3);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe with no expected entry at %0t", name, $time);
  endtask

  // Image memory: one outstanding read, configurable busy and return delay
  initial begin
    bit          pend;
    int          cnt;
    logic [40:0] paddr;
    logic        prev_busy;
    pend = 0; cnt = 0; paddr = '0; prev_busy = 1'b0;
    bus.mem_busy = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (bus.mem_rd || bus.mem_wr)) chk("strobe_after_busy", 64'(prev_busy), 64'd0);
      bus.mem_rvalid = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (cnt <= 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_byte(paddr);
            pend = 0;
          end else cnt--;
        end
        if (bus.mem_rd) begin
          chk("single_outstanding", 64'(pend), 64'd0);
          pend  = 1;
          paddr = bus.mem_addr;
          cnt   = rand_mode ? int'($urandom_range(4, 1)) : 1;
        end
      end
      bus.mem_busy = rand_mode ? 1'($urandom_range(1, 0)) : 1'b0;
      prev_busy = bus.mem_busy;
    end
  end

  // Drive buffers: data for an address appears one cycle after it is presented
  initial begin
    logic [13:0] prev_addr;
    prev_addr = '0;
    bus.sd_buff_din = '0;
    forever begin
      @(negedge clk_sys);
      for (int d = 0; d < int'(NDR); d++) bus.sd_buff_din[d] = buf_byte(d, prev_addr);
      prev_addr = bus.sd_buff_addr;
    end
  end

  // Output monitor
  initial begin
    logic [NDR-1:0] prev_ack;
    beat_t       b;
    logic [40:0] a;
    int          e;
    prev_ack = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_ack = '0;
      end else begin
        if (bus.sd_buff_wr) begin
          bwr_seen++;
          if (exp_bwr.size() == 0) unexpected("sd_buff_wr");
          else begin
            b = exp_bwr.pop_front();
            chk("buff_addr", 64'(bus.sd_buff_addr), 64'(b.addr[13:0]));
            chk("buff_dout", 64'(bus.sd_buff_dout), 64'(b.data));
          end
        end
        if (bus.mem_rd) begin
          if (exp_mrd.size() == 0) unexpected("mem_rd");
          else begin
            a = exp_mrd.pop_front();
            chk("mem_rd_addr", 64'(bus.mem_addr), 64'(a));
          end
        end
        if (bus.mem_wr) begin
          if (exp_mwr.size() == 0) unexpected("mem_wr");
          else begin
            b = exp_mwr.pop_front();
            chk("mem_wr_addr", 64'(bus.mem_addr), 64'(b.addr));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(b.data));
          end
        end
        if (wr_err) werr_seen++;
        if (bus.sd_ack != prev_ack) begin
          chk("ack_onehot0", 64'($onehot0(bus.sd_ack)), 64'd1);
          if (prev_ack == '0) begin
            if (exp_ack.size() == 0) unexpected("sd_ack");
            else begin
              e = exp_ack.pop_front();
              chk("ack_drive", 64'(bus.sd_ack), 64'(1) << e);
            end
          end
        end
        prev_ack = bus.sd_ack;
      end
    end
  end

  task automatic push_read(input int d, input logic [31:0] lba, input logic [5:0] cnt);
    int n;
    logic [40:0] base;
    beat_t b;
    n = (int'(cnt[4:0]) + 1) * 512;
    base = {lba, 9'd0};
    exp_ack.push_back(d);
    for (int i = 0; i < n; i++) begin
      exp_mrd.push_back(base + 41'(i));
      b.addr = 41'(i);
      b.data = mem_byte(base + 41'(i));
      exp_bwr.push_back(b);
    end
  endtask

  task automatic push_write(input int d, input logic [31:0] lba, input logic [5:0] cnt, input bit ro);
    int n;
    beat_t b;
    n = (int'(cnt[4:0]) + 1) * 512;
    exp_ack.push_back(d);
    if (ro) werr_exp++;
    else begin
      for (int i = 0; i < n; i++) begin
        b.addr = {lba, 9'd0} + 41'(i);
        b.data = buf_byte(d, 14'(i));
        exp_mwr.push_back(b);
      end
    end
  endtask

  task automatic wait_ack(input int d, input bit any, input bit level, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_sys);
      if ((any ? (|bus.sd_ack) : bus.sd_ack[d]) == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_xfer(input int d, input bit rd, input logic [31:0] lba, input logic [5:0] cnt,
                          input bit ro, input int limit);
    bit ok;
    if (rd) push_read(d, lba, cnt);
    else    push_write(d, lba, cnt, ro);
    img_readonly       = ro;
    bus.sd_lba[d]      = lba;
    bus.sd_blk_cnt[d]  = cnt;
    if (rd) bus.sd_rd[d] = 1'b1;
    else    bus.sd_wr[d] = 1'b1;
    wait_ack(d, 1'b0, 1'b1, 50, ok);
    chk("ack_rise_timeout", 64'(ok), 64'd1);
    bus.sd_rd[d] = 1'b0;
    bus.sd_wr[d] = 1'b0;
    wait_ack(d, 1'b0, 1'b0, limit, ok);
    chk("ack_fall_timeout", 64'(ok), 64'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int start;
    reset = 1'b1;
    img_readonly = 1'b0;
    bus.sd_rd = '0;
    bus.sd_wr = '0;
    bus.sd_lba = '0;
    bus.sd_blk_cnt = '0;
    repeat (4) @(negedge clk_sys);
    chk("reset_sd_side",  64'({bus.sd_ack, bus.sd_buff_addr, bus.sd_buff_dout, bus.sd_buff_wr}), 64'd0);
    chk("reset_mem_side", 64'({bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.mem_wdata, wr_err}), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Single-block read from drive 0 at lba 3
    run_xfer(0, 1'b1, 32'd3, 6'd0, 1'b0, 20000);

    // Both drives requesting: round-robin from ptr 0 gives 1, 0, 1
    push_read(1, 32'd9, 6'd0);
    push_read(0, 32'd5, 6'd0);
    push_read(1, 32'd9, 6'd0);
    bus.sd_lba[0] = 32'd5;
    bus.sd_lba[1] = 32'd9;
    bus.sd_blk_cnt = '0;
    bus.sd_rd = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, 1'b1, 1'b1, 50, ok);
      chk("rr_ack_rise", 64'(ok), 64'd1);
      if (k == 2) bus.sd_rd = '0;
      wait_ack(0, 1'b1, 1'b0, 20000, ok);
      chk("rr_ack_fall", 64'(ok), 64'd1);
    end
    repeat (3) @(negedge clk_sys);

    // Two-block write from drive 1 at lba 0
    run_xfer(1, 1'b0, 32'd0, 6'd1, 1'b0, 40000);

    // Random busy and return delay; blk_cnt bit 5 is ignored (0x21 -> 2 blocks)
    rand_mode = 1'b1;
    run_xfer(0, 1'b1, 32'd7, 6'h21, 1'b0, 60000);
    run_xfer(1, 1'b0, 32'h1234_5678, 6'd0, 1'b0, 30000);
    rand_mode = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Write-protected image: no mem_wr, one wr_err pulse
    run_xfer(0, 1'b0, 32'd2, 6'd0, 1'b1, 20000);
    img_readonly = 1'b0;

    // Reset around byte 100 of a read, then a clean restart
    push_read(0, 32'd4, 6'd0);
    bus.sd_lba[0] = 32'd4;
    bus.sd_blk_cnt[0] = 6'd0;
    bus.sd_rd[0] = 1'b1;
    wait_ack(0, 1'b0, 1'b1, 50, ok);
    chk("rst_ack_rise", 64'(ok), 64'd1);
    bus.sd_rd[0] = 1'b0;
    start = bwr_seen;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_sys);
      if (bwr_seen >= start + 100) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_reach_byte100", 64'(ok), 64'd1);
    reset = 1'b1;
    #1;
    chk("midreset_sd_side",  64'({bus.sd_ack, bus.sd_buff_addr, bus.sd_buff_dout, bus.sd_buff_wr}), 64'd0);
    chk("midreset_mem_side", 64'({bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.mem_wdata, wr_err}), 64'd0);
    exp_bwr.delete();
    exp_mrd.delete();
    exp_ack.delete();
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    run_xfer(0, 1'b1, 32'd4, 6'd0, 1'b0, 20000);

    chk("queues_drained", 64'(exp_bwr.size() + exp_mwr.size() + exp_mrd.size() + exp_ack.size()), 64'd0);
    chk("wr_err_pulses", 64'(werr_seen), 64'(werr_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
